// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - RAM user read port plus output stream bundle
//
// Signals:
//   oe, rd_addr   read strobe and address toward the RAM (reader drives)
//   rd_data       RAM read data, valid the cycle after oe (RAM side drives)
//   wr_active     host write to the RAM in this cycle (RAM side drives)
//   out_data, out_valid  stream toward user logic (reader drives)
//   out_ready     stream back-pressure (user logic drives)
// master = the reader, slave = the RAM and stream consumer.

interface ram_stream_reader_if #(
    parameter int B = 32,
    parameter int W = 10
);
    logic         oe;
    logic [W-1:0] rd_addr;
    logic [B-1:0] rd_data;
    logic         wr_active;
    logic [B-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output oe, rd_addr, out_data, out_valid,
        input  rd_data, wr_active, out_ready
    );

    modport slave (
        input  oe, rd_addr, out_data, out_valid,
        output rd_data, wr_active, out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - drains a block of RAM words onto a valid/ready stream
//
// Ports:
//   clk        single clock shared with the RAM
//   reset      asynchronous, active-high
//   start      one-cycle transfer request, honoured only in IDLE
//   base_addr  first word address, sampled with start
//   length     word count (0 legal), sampled with start
//   bus        RAM read port and output stream (ram_stream_reader_if.master)
//   busy       high while reads are issuing or draining
//   done       one-cycle completion pulse
//
// Reads are only issued when the 2-entry output FIFO is guaranteed room for
// the returning word, counting words already in flight and the word leaving
// this cycle. That credit check is what makes back-pressure lossless.

module ram_stream_reader #(
    parameter int B = 32,
    parameter int W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [W-1:0]         base_addr,
    input  logic [W:0]           length,
    ram_stream_reader_if.master  bus,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [W-1:0] ptr;
    logic [W:0]   remaining;
    logic         inflight;

    logic [B-1:0] fifo_mem [2];
    logic         head;
    logic         tail;
    logic [1:0]   fifo_count;

    logic         push;
    logic         pop;
    logic         issue;
    logic [2:0]   credit_used;

    assign bus.oe        = issue;
    assign bus.rd_addr   = ptr;
    assign bus.out_data  = fifo_mem[head];
    assign bus.out_valid = (fifo_count != 2'd0);

    always_comb begin
        push        = inflight;
        pop         = (fifo_count != 2'd0) && bus.out_ready;
        // Slots committed after this cycle: buffered + returning - leaving.
        credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue       = (state == S_RUN) && (remaining != '0) &&
                      !bus.wr_active && (credit_used < 3'd2);
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (issue && (remaining == {{W{1'b0}}, 1'b1})) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Finish on the cycle the final word leaves, so done lands
                // exactly one cycle after the last stream transfer.
                if (!inflight &&
                    ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            remaining   <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            inflight <= issue;

            if ((state == S_IDLE) && start) begin
                ptr       <= base_addr;
                remaining <= length;
            end else if (issue) begin
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            if (push) begin
                fifo_mem[tail] <= bus.rd_data;
                tail           <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Sequencer that drains a block of words from the dual-port PCIe-side RAM through that RAM's user read port (`oe`/`rd_addr`/`rd_data`, 1-cycle read latency) and presents them in order on a valid/ready stream to user logic. The host fills the RAM over Avalon-MM; this block sits directly downstream on the user port. It also handles the RAM's rules: a read is dropped whenever a host write occurs in the same cycle, and the read address register returns to 0 when `oe` is low. Credit-based flow control guarantees no word is lost or duplicated under back-pressure.

## Interface
- `B`, 32, data word width; must match the RAM.
- `W`, 10, RAM address width; the RAM depth is 2^W.

- `clk`  in  1  single clock, shared with the RAM.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- `base_addr`  in  W  first word address; sampled with `start`.
- `length`  in  W+1  number of words; sampled with `start`; 0 is legal.
- `wr_active`  in  1  high in any cycle the host writes the RAM (the RAM's `~write_n`).
- `oe`  out  1  read strobe to the RAM.
- `rd_addr`  out  W  read address to the RAM.
- `rd_data`  in  B  RAM read data; valid the cycle after `oe` was high.
- `out_data`  out  B  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready; a transfer occurs when `out_valid && out_ready`.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: on `start`, latch `base_addr` into the read pointer and `length` into `remaining`.
    - If `length == 0`, go to DONE.
    - Otherwise go to RUN.
  - RUN: issue reads. When `remaining` reaches 0 after the last issue, go to DRAIN.
  - DRAIN: wait until the in-flight read has landed and the FIFO is empty, then go to DONE.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- `busy` is 1 in RUN and DRAIN, and 0 in IDLE and DONE.
- `start` is ignored outside IDLE.
- Output buffer: a 2-entry FIFO. `out_data`/`out_valid` are driven from the FIFO head register, never combinationally from `rd_data`.
- `inflight`: 1 if `oe` was high in the previous cycle, else 0.
- Issue condition (combinational): state == RUN, `remaining != 0`, `!wr_active`, and `fifo_count + inflight - (out_valid && out_ready) < 2`.
- `oe` equals the issue condition.
  - On issue: the read pointer increments modulo 2^W and `remaining` decrements.
- `rd_addr` always shows the read pointer register. Its value is irrelevant when `oe` is low.
- Address wrap: the pointer rolls from 2^W-1 to 0 with no error. If `length > 2^W`, words are re-read after the wrap.
- Capture: when `inflight` is 1, `rd_data` is pushed into the FIFO at the end of that cycle. The credit rule guarantees the FIFO never overflows.
- Simultaneous push and pop in one cycle: `fifo_count` is unchanged and order is preserved.
- `wr_active` high blocks issue only. Reads already in flight and the output stream continue normally.

## Timing
- Reset values: `oe` 0, `rd_addr` 0, `out_data` 0, `out_valid` 0, `busy` 0, `done` 0, state IDLE, FIFO empty, `inflight` 0.
- Reset asserted mid-transfer: all outputs return to their reset values immediately and FIFO contents are discarded.
- `start` is sampled at the edge ending cycle 0.
  - Cycle 1: RUN, and the first `oe` if it is allowed.
  - `oe` in cycle N → `rd_data` valid in cycle N+1 → `out_valid` with that word from cycle N+2.
- Minimum latency from `start` to the first `out_valid` is 3 cycles.
- With `out_ready` held at 1 and no `wr_active`, throughput is 1 word per cycle.
- `done` is high in the cycle after the last stream transfer.
- For `length == 0`, `done` is high in cycle 1, `busy` never rises and `oe` is never asserted.
- `out_valid`, once high, stays high with `out_data` stable until it is accepted.

## Test plan
- Full-rate transfer:
  - Stimulus: `ram[5..8] = 0xA0..0xA3`, `base_addr = 5`, `length = 4`, `out_ready = 1`, start in cycle 0.
  - Required: `oe` in cycles 1–4 with `rd_addr` 5..8; stream 0xA0..0xA3 in cycles 3–6; `done` in cycle 7; `busy` high in cycles 1–6.
- Wrap-around:
  - Stimulus: `W = 10`, `base_addr = 1022`, `length = 4`.
  - Required: `rd_addr` sequence 1022, 1023, 0, 1; stream is `ram[1022]`, `ram[1023]`, `ram[0]`, `ram[1]`.
- Back-pressure:
  - Stimulus: `length = 6`, `out_ready = 0` in cycles 3–10, then 1.
  - Required: at most 2 words are buffered plus in flight, `oe` stays low while stalled, all 6 words arrive in order with no duplicates, and `out_data` is stable during the stall.
- Host-write collision:
  - Stimulus: `wr_active = 1` in cycles 2–4 during a 4-word transfer.
  - Required: `oe` is low in cycles 2–4 and the stream is still the correct 4 words in order.
- Zero length:
  - Stimulus: `length = 0`.
  - Required: no `oe`, `done` in cycle 1, `busy` stays 0. A second `start` issued in cycle 1 is ignored.
- Reset mid-run:
  - Stimulus: assert `reset` in cycle 4 of an 8-word transfer, then start a new 2-word transfer.
  - Required: all outputs go to their reset values immediately, and the new transfer completes correctly with no stale data.
